mix_columns_seq: RTL and testbench
==================================

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 Parameters: none; the block has a fixed 128-bit AES state width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  in_state (and in_inv) valid.
REQ-005 in_ready  output  1  block can accept a new state.
REQ-006 in_state  input  128  AES state; byte s0 = [127:120] ... s15 = [7:0]; column c = bytes 4c..4c+3.
REQ-007 in_inv  input  1  select InvMixColumns; present only with INV_MIX_COLUMNS_EN.
REQ-008 out_valid  output  1  out_state holds a finished result.
REQ-009 out_ready  input  1  consumer accepts out_state.
REQ-010 out_state  output  128  transformed state, same byte order as in_state.
REQ-011 busy  output  1  high in RUN or DONE.

Function
REQ-012 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-013 IDLE: in_ready=1; in_valid=1 SHALL latch in_state into the working register, clear col_cnt to 0, latch in_inv, and enter RUN.
REQ-014 RUN: each cycle, replace column col_cnt of the working register with the MixColumns (or InvMixColumns) result of that column, then increment col_cnt.
REQ-015 Column order: 0,1,2,3 (MSB column first); col_cnt is 2 bits; after column 3 is processed (col_cnt wraps to 0), enter DONE.
REQ-016 Latency: out_valid SHALL rise exactly 4 clock edges after the accepting edge.
REQ-017 Column math over GF(2^8), P = 0x11B, using the multiply-by-2 primitive: forward matrix rows {2,3,1,1} rotated; inverse rows {0E,0B,0D,09} rotated.
REQ-018 DONE: out_valid=1, out_state = working register, stable until handshake; out_valid&&out_ready SHALL return to IDLE on the next edge.
REQ-019 in_ready=0 in RUN and DONE; in_valid there SHALL be ignored, with no same-cycle accept on the DONE->IDLE edge.
REQ-020 Changes on in_state/in_inv after acceptance SHALL NOT affect the result.
REQ-021 out_state SHALL hold its last value in IDLE; only out_valid qualifies it.

Reset
REQ-022 rst_n low SHALL force IDLE, col_cnt=0, working register=0, out_valid=0, busy=0, and in_ready=1 after release, regardless of the current state.
REQ-023 A reset mid-RUN or in DONE SHALL discard the operation; no partial result is ever presented.

Configuration
REQ-024 Macro INV_MIX_COLUMNS_EN defined: in_inv port exists and selects the inverse matrix per operation.
REQ-025 Macro undefined: no in_inv port; forward MixColumns only; no inverse logic synthesized.

Structure
REQ-026 Shared package aes_pkg: FSM state typedef, column-count width constant, AES_POLY = 0x11B, byte-slice index helpers.
REQ-027 Sub-module mix_column: combinational 32-bit column transform built from instances of the existing multiply-by-2 block, with inverse input under INV_MIX_COLUMNS_EN; the sequencer instantiates one copy shared across the 4 columns.

Verification
REQ-028 FIPS-197 column: any column = db135345 -> 8e4da1bc; also f20a225c -> 9fdc589d, 2d26314c -> 4d7ebdf8.
REQ-029 Identity columns: state of all 01 bytes -> all 01; all c6 -> all c6; d4d4d4d5 -> d5d5d7d6.
REQ-030 Latency/handshake: accept at edge N -> out_valid at N+4; hold out_ready=0 for 10 cycles -> out_state stable and in_ready=0; out_ready=1 -> IDLE at next edge; in_valid high throughout -> next accept no earlier than the edge after return to IDLE.
REQ-031 Reset: assert rst_n low after 2 RUN cycles -> out_valid=0 and busy=0 immediately; after release, a new input produces the correct result with no residue.
REQ-032 Inverse (macro on): in_inv=1 on column 8e4da1bc -> db135345; a forward then inverse round trip on a random 128-bit state returns the original.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the MixColumns sequencer: FSM states,
// column counter width, field polynomial and state slice helpers.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mc_state_e;

    localparam int COL_CNT_W = 2;
    localparam logic [8:0] AES_POLY = 9'h11B;

    // MSB of column c inside the 128-bit state (column 0 = [127:96])
    function automatic int unsigned col_hi(input logic [COL_CNT_W-1:0] c);
        return 127 - 32 * int'(c);
    endfunction

    // MSB of byte b inside the 128-bit state (byte 0 = [127:120])
    function automatic int unsigned byte_hi(input logic [3:0] b);
        return 127 - 8 * int'(b);
    endfunction

endpackage

// File: rtl/gf_mul2.sv
// Multiply-by-2 (xtime) in GF(2^8) reduced by the AES polynomial.
module gf_mul2
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    logic [7:0] red;

    assign red = AES_POLY[7:0];
    assign y   = {a[6:0], 1'b0} ^ (a[7] ? red : 8'h00);

endmodule

// File: rtl/mix_column.sv
// Combinational 32-bit MixColumns column transform; the inverse matrix
// is built only when INV_MIX_COLUMNS_EN is defined.
module mix_column (
    input  logic [31:0] col,
`ifdef INV_MIX_COLUMNS_EN
    input  logic        inv,
`endif
    output logic [31:0] res
);

    logic [7:0] a   [4];
    logic [7:0] x2  [4];
    logic [31:0] fwd;

    for (genvar i = 0; i < 4; i++) begin : g_fwd
        assign a[i] = col[31-8*i -: 8];

        gf_mul2 u_m2 (.a(a[i]), .y(x2[i]));

        assign fwd[31-8*i -: 8] = x2[i] ^ x2[(i+1)%4] ^ a[(i+1)%4]
                                ^ a[(i+2)%4] ^ a[(i+3)%4];
    end

`ifdef INV_MIX_COLUMNS_EN
    logic [7:0] x4  [4];
    logic [7:0] x8  [4];
    logic [7:0] m9  [4];
    logic [7:0] mb  [4];
    logic [7:0] md  [4];
    logic [7:0] me  [4];
    logic [31:0] bwd;

    // 9/B/D/E multiples composed from the doubling chain
    for (genvar i = 0; i < 4; i++) begin : g_inv
        gf_mul2 u_m4 (.a(x2[i]), .y(x4[i]));
        gf_mul2 u_m8 (.a(x4[i]), .y(x8[i]));

        assign m9[i] = x8[i] ^ a[i];
        assign mb[i] = x8[i] ^ x2[i] ^ a[i];
        assign md[i] = x8[i] ^ x4[i] ^ a[i];
        assign me[i] = x8[i] ^ x4[i] ^ x2[i];

        assign bwd[31-8*i -: 8] = me[i] ^ mb[(i+1)%4]
                                ^ md[(i+2)%4] ^ m9[(i+3)%4];
    end

    assign res = inv ? bwd : fwd;
`else
    assign res = fwd;
`endif

endmodule

// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns over a 128-bit state, one column per cycle.
// Define INV_MIX_COLUMNS_EN to add the in_inv port and InvMixColumns.
module mix_columns_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
`ifdef INV_MIX_COLUMNS_EN
    input  logic         in_inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    mc_state_e state;
    mc_state_e state_nx;

    logic [COL_CNT_W-1:0] col_cnt;
    logic [127:0]         work;
    logic [31:0]          col_in;
    logic [31:0]          col_out;

`ifdef INV_MIX_COLUMNS_EN
    logic inv_q;
`endif

    assign col_in    = work[col_hi(col_cnt) -: 32];
    assign out_state = work;

    mix_column u_mix (
        .col (col_in),
`ifdef INV_MIX_COLUMNS_EN
        .inv (inv_q),
`endif
        .res (col_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                if (col_cnt == COL_CNT_W'(3)) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                busy     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work    <= '0;
            col_cnt <= '0;
`ifdef INV_MIX_COLUMNS_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        work    <= in_state;
                        col_cnt <= '0;
`ifdef INV_MIX_COLUMNS_EN
                        inv_q   <= in_inv;
`endif
                    end
                end
                RUN: begin
                    work[col_hi(col_cnt) -: 32] <= col_out;
                    col_cnt <= col_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed-vector bench for mix_columns_seq; inverse checks run only
// when INV_MIX_COLUMNS_EN is defined.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
`ifdef INV_MIX_COLUMNS_EN
    logic         in_inv;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int total = 0;
    int bad   = 0;

    mix_columns_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
`ifdef INV_MIX_COLUMNS_EN
        .in_inv    (in_inv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Accept s, scramble inputs, measure latency, collect and hand off result
    task automatic do_op(input string tag, input logic [127:0] s,
                         output logic [127:0] r);
        int k;
        @(negedge clk);
        in_state  = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_state = ~s;
        for (k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) break;
        end
        chk({tag, "_lat"}, 128'(k), 128'd4);
        r = out_state;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string        tag;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [127:0] r;
        logic [127:0] r2;
        logic [127:0] held;
        logic [127:0] rnd;
        bit           stable;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b0;
`ifdef INV_MIX_COLUMNS_EN
        in_inv    = 1'b0;
`endif
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_out_state", out_state, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd1);

        vecs.push_back('{"fips_col", {4{32'hdb135345}}, {4{32'h8e4da1bc}}});
        vecs.push_back('{"mixed",
            {32'hdb135345, 32'hf20a225c, 32'h2d26314c, 32'hd4d4d4d5},
            {32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8, 32'hd5d5d7d6}});
        vecs.push_back('{"all01", {16{8'h01}}, {16{8'h01}}});
        vecs.push_back('{"allc6", {16{8'hc6}}, {16{8'hc6}}});
        vecs.push_back('{"fips_rnd1",
            128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5,
            128'h046681e5_e0cb199a_48f8d37a_2806264c});
        vecs.push_back('{"rev_order",
            {32'hd4d4d4d5, 32'h2d26314c, 32'hf20a225c, 32'hdb135345},
            {32'hd5d5d7d6, 32'h4d7ebdf8, 32'h9fdc589d, 32'h8e4da1bc}});

        foreach (vecs[i]) begin
            do_op(vecs[i].tag, vecs[i].din, r);
            chk(vecs[i].tag, r, vecs[i].dout);
        end

        // Backpressure with in_valid held high
        @(negedge clk);
        in_state  = {4{32'hdb135345}};
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_state = {4{32'hf20a225c}};
        repeat (4) @(posedge clk);
        #1;
        chk("bp_valid", 128'(out_valid), 128'd1);
        held   = out_state;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_state !== held || in_ready !== 1'b0 || !out_valid)
                stable = 1'b0;
        end
        chk("bp_stable", 128'(stable), 128'd1);
        chk("bp_result", held, {4{32'h8e4da1bc}});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_ready", 128'(in_ready), 128'd1);
        chk("bp_idle_busy", 128'(busy), 128'd0);
        chk("bp_idle_state", out_state, {4{32'h8e4da1bc}});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_reaccept", 128'(busy), 128'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("bp2_valid", 128'(out_valid), 128'd1);
        chk("bp2_result", out_state, {4{32'h9fdc589d}});
        @(posedge clk);
        #1;

        // Reset mid-RUN
        @(negedge clk);
        in_state = {4{32'h2d26314c}};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(out_valid), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_state", out_state, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst", {4{32'hd4d4d4d5}}, r);
        chk("post_rst", r, {4{32'hd5d5d7d6}});

`ifdef INV_MIX_COLUMNS_EN
        in_inv = 1'b1;
        do_op("inv_col", {4{32'h8e4da1bc}}, r);
        chk("inv_col", r, {4{32'hdb135345}});
        rnd = {$urandom, $urandom, $urandom, $urandom};
        in_inv = 1'b0;
        do_op("rt_fwd", rnd, r);
        in_inv = 1'b1;
        do_op("rt_inv", r, r2);
        chk("round_trip", r2, rnd);
        in_inv = 1'b0;
`else
        rnd = '0;
        r2  = rnd;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
